lcd_spi_rx: RTL and testbench
=============================

# lcd_spi_rx

SPI-slave front end that feeds the LCD write engine. Receives framed command/pixel bytes from the host MCU over the shared SPI pins, tags each byte with an LCD register-select (RS) bit, and buffers them in a first-word-fall-through FIFO. The FIFO output is presented on a valid/ready byte stream that the `lcd` block consumes. Sits between the top-level SPI pins and `lcd`, clocked from the SB_HFOSC clock.

## Interface
Parameters:
- `DEPTH_LOG2`, 4, FIFO depth is 2^DEPTH_LOG2 entries (16); each entry is 9 bits {rs, data[7:0]}.

Ports:
- `i_clk`  in  1  system clock (SB_HFOSC output); one clock domain.
- `i_rst`  in  1  reset, asynchronous, active-high.
- `i_spi_sck`  in  1  SPI clock, mode 0, asynchronous to `i_clk`.
- `i_spi_cs`  in  1  SPI chip select, active-low, asynchronous.
- `i_spi_mosi`  in  1  SPI data in, MSB first.
- `o_spi_miso`  out  1  status byte out during the header byte, 0 otherwise.
- `o_data`  out  8  FIFO head byte.
- `o_rs`  out  1  RS tag of head byte (0 = command, 1 = data).
- `o_valid`  out  1  head entry valid.
- `i_ready`  in  1  consumer accepts head when `o_valid && i_ready`.
- `o_overflow`  out  1  sticky: a byte was dropped because the FIFO was full.
- `o_busy`  out  1  synchronized CS asserted (frame in progress).

## Operation
- SCK, CS, and MOSI each pass through a 2-FF synchronizer; a third register on SCK and CS provides edge detection. SCK frequency must not exceed `i_clk`/4.
- FSM states: IDLE, HEADER, DATA.
  - IDLE -> HEADER on a synchronized CS falling edge. The bit counter is cleared. The status byte {overflow, full, 1'b0, count[4:0]} is latched into the MISO shift register.
  - HEADER: sample MOSI on each synced SCK rising edge and shift MISO on each falling edge. After 8 bits, store header bit0 as the frame RS and go to DATA. Header bits 7:1 are ignored. The header is never pushed.
  - DATA: every completed 8-bit byte is pushed as {frame RS, byte}. The bit counter wraps 7 -> 0, and any number of bytes per frame is allowed.
  - Any state -> IDLE on a synced CS rising edge. A partial byte (1–7 bits) is discarded and no push occurs. A frame containing only a header pushes nothing.
- `o_spi_miso` is 0 in IDLE and DATA. In HEADER it drives the MSB of the status shift register.
- FIFO behaviour:
  - Binary read/write pointers plus a count of 0..2^DEPTH_LOG2 (5 bits).
  - Push while full: the byte is dropped and `o_overflow` is set. `o_overflow` clears only on `i_rst`.
  - Push and pop in the same cycle while full: both take effect, nothing is dropped, and the count is unchanged.
  - Push and pop in the same cycle while empty: pop is ignored (`o_valid` is 0), and the push is stored.
- Output behaviour:
  - `o_data` and `o_rs` are combinational from the FIFO head.
  - They are held stable while `o_valid && !i_ready`.
  - When the FIFO is empty, `o_valid` = 0 and `o_data` is don't-care; the bench must not check it.

## Timing
- Reset values: `o_valid` 0, `o_data` 0, `o_rs` 0, `o_overflow` 0, `o_busy` 0, `o_spi_miso` 0. FSM in IDLE, FIFO empty.
- Push latency: a byte is written into the FIFO 4 `i_clk` cycles (±1 for async sampling) after the pin-level 8th SCK rising edge. `o_valid` rises the cycle after the write.
- Pop: entry removed at the `i_clk` edge where `o_valid && i_ready`. The next entry, if present, is visible in the same cycle after that edge, giving a zero-bubble throughput of 1 byte/cycle.
- `o_busy` follows pin CS (inverted) with 2 cycles of delay.
- `i_rst` mid-frame: FIFO emptied and FSM forced to IDLE. After release, the block ignores SPI activity until the next CS falling edge.
- MISO status: the first bit is valid from the synced CS falling edge until the first SCK falling edge. Host sampling at SCK rising edge meets timing because SCK ≤ `i_clk`/4.

## Test plan
- Reset, then a frame with header 0x01 and data 0xA5, 0x3C, with `i_ready`=1 -> stream shows {rs=1, 0xA5}, then {rs=1, 0x3C}; `o_overflow` stays 0.
- Header 0x00 plus byte 0x2C, then CS raised after 5 bits of a second byte -> exactly one entry {rs=0, 0x2C}; the partial byte is discarded.
- `i_ready`=0 and a frame of 18 data bytes 0x00..0x11 -> 16 entries 0x00..0x0F are held; `o_overflow`=1. Draining with `i_ready`=1 yields 0x00..0x0F in order, after which `o_valid`=0.
- FIFO filled to 16, then `i_ready` pulsed in the same cycle as a push of 0x77 -> no overflow; 0x77 appears as the last entry.
- 3 entries queued with `i_ready`=0, then a new header-only frame -> MISO returns 0x03, nothing is pushed, and the count is still 3.
- Assert `i_rst` after 12 bits of a frame -> all outputs return to reset values; the next full frame with header 0x01 and byte 0x55 delivers {rs=1, 0x55}.

Source files
------------

// File: rtl/lcd_spi_rx.sv
// SPI-slave receiver for the LCD write engine: framed bytes are tagged with
// an RS bit from the frame header and queued in a first-word-fall-through FIFO.
module lcd_spi_rx #(
   parameter int unsigned DEPTH_LOG2 = 4
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_spi_sck,
   input  logic       i_spi_cs,
   input  logic       i_spi_mosi,
   output logic       o_spi_miso,
   output logic [7:0] o_data,
   output logic       o_rs,
   output logic       o_valid,
   input  logic       i_ready,
   output logic       o_overflow,
   output logic       o_busy
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
   localparam int unsigned CNT_W = DEPTH_LOG2 + 1;
   localparam int unsigned ENT_W = 9;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_HEADER = 2'd1;
   localparam logic [1:0] ST_DATA   = 2'd2;

   logic [2:0] sck_s;
   logic [2:0] cs_s;
   logic [1:0] mosi_s;
   logic       busy_q;

   logic       sck_rise_c;
   logic       sck_fall_c;
   logic       cs_rise_c;
   logic       cs_fall_c;
   logic       mosi_bit_c;

   logic [1:0] state;
   logic [1:0] state_nxt;
   logic [2:0] bit_cnt;
   logic [6:0] shift_in;
   logic [7:0] shift_nxt_c;
   logic [7:0] miso_sr;
   logic       frame_rs;
   logic       push_q;
   logic [ENT_W-1:0] push_word;

   logic [ENT_W-1:0]      mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic [CNT_W-1:0]      count;
   logic [CNT_W-1:0]      count_nxt_c;
   logic                  valid_q;
   logic                  overflow_q;
   logic                  full_c;
   logic                  pop_c;
   logic                  wr_c;
   logic [7:0]            status_c;
   logic [ENT_W-1:0]      head_c;

   // Synchronizers; CS resets to the asserted level so a frame already in
   // progress when reset releases produces no falling edge and is ignored.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         sck_s  <= 3'b000;
         cs_s   <= 3'b000;
         mosi_s <= 2'b00;
         busy_q <= 1'b0;
      end else begin
         sck_s  <= {sck_s[1:0], i_spi_sck};
         cs_s   <= {cs_s[1:0], i_spi_cs};
         mosi_s <= {mosi_s[0], i_spi_mosi};
         busy_q <= ~cs_s[0];
      end
   end

   assign sck_rise_c  = sck_s[1] & ~sck_s[2];
   assign sck_fall_c  = ~sck_s[1] & sck_s[2];
   assign cs_rise_c   = cs_s[1] & ~cs_s[2];
   assign cs_fall_c   = ~cs_s[1] & cs_s[2];
   assign mosi_bit_c  = mosi_s[1];
   assign shift_nxt_c = {shift_in, mosi_bit_c};

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (cs_rise_c) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:   if (cs_fall_c) state_nxt = ST_HEADER;
            ST_HEADER: if (sck_rise_c && (bit_cnt == 3'd7)) state_nxt = ST_DATA;
            ST_DATA:   state_nxt = ST_DATA;
            default:   state_nxt = ST_IDLE;
         endcase
      end
   end

   // Bit/byte assembly, MISO status shifter and push request
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         bit_cnt   <= 3'd0;
         shift_in  <= 7'd0;
         miso_sr   <= 8'd0;
         frame_rs  <= 1'b0;
         push_q    <= 1'b0;
         push_word <= '0;
      end else begin
         push_q <= 1'b0;
         if (cs_rise_c) begin
            bit_cnt <= 3'd0;
            miso_sr <= 8'd0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (cs_fall_c) begin
                     bit_cnt <= 3'd0;
                     miso_sr <= status_c;
                  end
               end
               ST_HEADER: begin
                  if (sck_rise_c) begin
                     shift_in <= shift_nxt_c[6:0];
                     bit_cnt  <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) begin
                        frame_rs <= mosi_bit_c;
                        miso_sr  <= 8'd0;
                     end
                  end else if (sck_fall_c) begin
                     miso_sr <= {miso_sr[6:0], 1'b0};
                  end
               end
               ST_DATA: begin
                  if (sck_rise_c) begin
                     shift_in <= shift_nxt_c[6:0];
                     bit_cnt  <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) begin
                        push_q    <= 1'b1;
                        push_word <= {frame_rs, shift_nxt_c};
                     end
                  end
               end
               default: begin
                  bit_cnt <= 3'd0;
               end
            endcase
         end
      end
   end

   assign o_spi_miso = miso_sr[7];
   assign o_busy     = busy_q;

   // FIFO control: a pop while full makes room for a same-cycle push
   assign full_c   = (count == CNT_W'(DEPTH));
   assign pop_c    = valid_q & i_ready;
   assign wr_c     = push_q & (~full_c | pop_c);
   assign status_c = {overflow_q, full_c, 1'b0, 5'(count)};

   always_comb begin
      count_nxt_c = count;
      case ({wr_c, pop_c})
         2'b10:   count_nxt_c = count + CNT_W'(1);
         2'b01:   count_nxt_c = count - CNT_W'(1);
         default: count_nxt_c = count;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (wr_c) begin
         mem[wr_ptr] <= push_word;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         valid_q    <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         if (wr_c) begin
            wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
         end
         if (pop_c) begin
            rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
         end
         count   <= count_nxt_c;
         valid_q <= (count_nxt_c != '0);
         if (push_q && full_c && !pop_c) begin
            overflow_q <= 1'b1;
         end
      end
   end

   // Head is gated so the outputs read zero while the FIFO is empty
   assign head_c     = mem[rd_ptr];
   assign o_valid    = valid_q;
   assign o_data     = valid_q ? head_c[7:0] : 8'h00;
   assign o_rs       = valid_q & head_c[8];
   assign o_overflow = overflow_q;

endmodule

// File: tb/tb_lcd_spi_rx.sv
// Directed bench for lcd_spi_rx: SPI frames driven bit by bit, output stream
// captured into a queue and compared against hand-computed entries.
module tb_lcd_spi_rx;

   logic       clk;
   logic       rst;
   logic       sck;
   logic       cs;
   logic       mosi;
   logic       miso;
   logic [7:0] data;
   logic       rs;
   logic       valid;
   logic       ready;
   logic       overflow;
   logic       busy;

   int unsigned n_checks;
   int unsigned n_errors;
   logic [8:0]  got_q[$];

   lcd_spi_rx #(.DEPTH_LOG2(4)) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_spi_sck  (sck),
      .i_spi_cs   (cs),
      .i_spi_mosi (mosi),
      .o_spi_miso (miso),
      .o_data     (data),
      .o_rs       (rs),
      .o_valid    (valid),
      .i_ready    (ready),
      .o_overflow (overflow),
      .o_busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Record every accepted entry; inputs only change at posedge+1
   always @(negedge clk) begin
      if (valid && ready) got_q.push_back({rs, data});
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One SCK period of 8 clk cycles; optionally pulse ready in the cycle
   // that ends with the FIFO write of this (8th) bit.
   task automatic spi_bit(input logic b, input bit pulse, output logic m);
      mosi = b;
      tick(4);
      m   = miso;
      sck = 1'b1;
      if (pulse) begin
         tick(3);
         ready = 1'b1;
         tick(1);
         ready = 1'b0;
      end else begin
         tick(4);
      end
      sck = 1'b0;
   endtask

   task automatic spi_byte(input logic [7:0] b, input bit pulse, output logic [7:0] m);
      for (int i = 7; i >= 0; i--) spi_bit(b[i], pulse && (i == 0), m[i]);
   endtask

   task automatic cs_low();
      cs = 1'b0;
      tick(8);
   endtask

   task automatic cs_high();
      tick(4);
      cs = 1'b1;
      tick(8);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(3);
      rst = 1'b0;
      tick(4);
   endtask

   task automatic check_queue(input string tag, input int idx, input logic [8:0] exp);
      logic [8:0] g;
      g = (got_q.size() > idx) ? got_q[idx] : 9'h1FF;
      check(tag, 32'(g), 32'(exp));
   endtask

   initial begin
      logic [7:0] m;
      logic       mb;
      n_checks = 0;
      n_errors = 0;
      rst = 1'b1; sck = 1'b0; cs = 1'b1; mosi = 1'b0; ready = 1'b0;
      tick(3);
      rst = 1'b0;
      tick(4);

      // Reset state
      check("rst_valid", 32'(valid), 32'h0);
      check("rst_data", 32'(data), 32'h0);
      check("rst_rs", 32'(rs), 32'h0);
      check("rst_overflow", 32'(overflow), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_miso", 32'(miso), 32'h0);

      // Data frame with rs=1, consumer always ready
      ready = 1'b1;
      got_q.delete();
      cs_low();
      check("t1_busy", 32'(busy), 32'h1);
      spi_byte(8'h01, 1'b0, m);
      check("t1_status", 32'(m), 32'h00);
      spi_byte(8'hA5, 1'b0, m);
      check("t1_miso_data", 32'(m), 32'h00);
      spi_byte(8'h3C, 1'b0, m);
      cs_high();
      check("t1_busy_end", 32'(busy), 32'h0);
      check("t1_count", 32'(got_q.size()), 32'd2);
      check_queue("t1_e0", 0, 9'h1A5);
      check_queue("t1_e1", 1, 9'h13C);
      check("t1_overflow", 32'(overflow), 32'h0);
      check("t1_valid_end", 32'(valid), 32'h0);

      // Partial trailing byte is discarded
      got_q.delete();
      cs_low();
      spi_byte(8'h00, 1'b0, m);
      spi_byte(8'h2C, 1'b0, m);
      for (int i = 0; i < 5; i++) spi_bit(1'b1, 1'b0, mb);
      cs_high();
      tick(4);
      check("t2_count", 32'(got_q.size()), 32'd1);
      check_queue("t2_e0", 0, 9'h02C);

      // Overflow: 18 bytes into a 16-entry FIFO with consumer stalled
      ready = 1'b0;
      got_q.delete();
      cs_low();
      spi_byte(8'h00, 1'b0, m);
      for (int i = 0; i < 18; i++) spi_byte(8'(i), 1'b0, m);
      cs_high();
      check("t3_overflow", 32'(overflow), 32'h1);
      check("t3_valid", 32'(valid), 32'h1);
      check("t3_head", 32'({rs, data}), 32'h000);
      tick(3);
      check("t3_head_held", 32'({rs, data}), 32'h000);
      cs_low();
      spi_byte(8'h00, 1'b0, m);
      cs_high();
      check("t3_status_full", 32'(m), 32'hD0);
      ready = 1'b1;
      tick(20);
      ready = 1'b0;
      check("t3_count", 32'(got_q.size()), 32'd16);
      for (int i = 0; i < 16; i++) check_queue($sformatf("t3_e%0d", i), i, 9'(i));
      check("t3_valid_end", 32'(valid), 32'h0);

      // Push and pop in the same cycle while full
      do_reset();
      ready = 1'b0;
      got_q.delete();
      cs_low();
      spi_byte(8'h01, 1'b0, m);
      for (int i = 0; i < 16; i++) spi_byte(8'h80 + 8'(i), 1'b0, m);
      spi_byte(8'h77, 1'b1, m);
      cs_high();
      check("t4_overflow", 32'(overflow), 32'h0);
      check("t4_head", 32'({rs, data}), 32'h181);
      ready = 1'b1;
      tick(20);
      ready = 1'b0;
      check("t4_count", 32'(got_q.size()), 32'd17);
      for (int i = 0; i < 16; i++) check_queue($sformatf("t4_e%0d", i), i, 9'h180 + 9'(i));
      check_queue("t4_last", 16, 9'h177);
      check("t4_valid_end", 32'(valid), 32'h0);

      // Header-only frame reports the count and pushes nothing
      do_reset();
      ready = 1'b0;
      got_q.delete();
      cs_low();
      spi_byte(8'h00, 1'b0, m);
      spi_byte(8'h11, 1'b0, m);
      spi_byte(8'h22, 1'b0, m);
      spi_byte(8'h33, 1'b0, m);
      cs_high();
      check("t5_miso_idle", 32'(miso), 32'h0);
      cs_low();
      spi_byte(8'h00, 1'b0, m);
      cs_high();
      check("t5_status", 32'(m), 32'h03);
      check("t5_head", 32'({rs, data}), 32'h011);
      ready = 1'b1;
      tick(10);
      ready = 1'b0;
      check("t5_count", 32'(got_q.size()), 32'd3);
      check_queue("t5_e0", 0, 9'h011);
      check_queue("t5_e1", 1, 9'h022);
      check_queue("t5_e2", 2, 9'h033);
      check("t5_valid_end", 32'(valid), 32'h0);

      // Reset in the middle of a frame
      do_reset();
      cs_low();
      spi_byte(8'h01, 1'b0, m);
      spi_byte(8'h99, 1'b0, m);
      cs_high();
      check("t6_pre_valid", 32'(valid), 32'h1);
      cs_low();
      spi_byte(8'h01, 1'b0, m);
      for (int i = 0; i < 4; i++) spi_bit(1'b1, 1'b0, mb);
      rst = 1'b1;
      tick(2);
      check("t6_valid", 32'(valid), 32'h0);
      check("t6_data", 32'(data), 32'h0);
      check("t6_rs", 32'(rs), 32'h0);
      check("t6_overflow", 32'(overflow), 32'h0);
      check("t6_busy", 32'(busy), 32'h0);
      check("t6_miso", 32'(miso), 32'h0);
      rst = 1'b0;
      tick(4);
      spi_byte(8'hFF, 1'b0, m);
      spi_byte(8'hFF, 1'b0, m);
      cs_high();
      check("t6_ignored", 32'(valid), 32'h0);
      ready = 1'b1;
      got_q.delete();
      cs_low();
      spi_byte(8'h01, 1'b0, m);
      spi_byte(8'h55, 1'b0, m);
      cs_high();
      check("t6_count", 32'(got_q.size()), 32'd1);
      check_queue("t6_e0", 0, 9'h155);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
